header_tuple_collector: RTL and testbench
=========================================

// Module: header_tuple_collector
// PURPOSE
//  Parametrised successor to the header engine front end. Assembles the 104-bit 5-tuple
//  {sa,da,sp,dp,prot} from the preprocessing word stream, validates completeness, and
//  buffers finished tuples in a DEPTH-entry FIFO. The FIFO drains over valid/ready to the
//  rule-processing stage. Adds a strict/lenient mode, drop accounting and overflow handling.
// PARAMETERS
//  DEPTH   4   tuple FIFO entries; power of two, 2..64
//  STRICT  1   1: drop incomplete/duplicate/illegal headers; 0: zero-fill missing, last-wins dups
//  CNT_W   10  width of the header and drop counters; counters saturate at all-ones
// PORTS
//  clk        in   1    single clock
//  rst_n      in   1    asynchronous, active-low reset
//  data       in   32   preprocessing word
//  sa         in   1    data holds source address
//  da         in   1    data holds destination address
//  sp_dp      in   1    data holds {sport[31:16],dport[15:0]}
//  prot       in   1    data[7:0] holds the protocol number
//  soh        in   1    start of header (same cycle as the first word)
//  eoh        in   1    end of header (same cycle as the last word)
//  hReady     out  1    may accept a new header; low when the FIFO is full
//  out_tuple  out  104  {sa[103:72],da[71:40],sp[39:24],dp[23:8],prot[7:0]}
//  out_valid  out  1    FIFO head valid (first-word fall-through)
//  out_ready  in   1    consumer accepts the head when out_valid && out_ready
//  hdr_cnt    out  CNT_W  headers committed to the FIFO
//  drop_cnt   out  CNT_W  headers discarded (error or overflow)
//  overflow   out  1    one-cycle pulse when eoh commit is lost because the FIFO is full
// BEHAVIOUR
//  Reset: FSM=IDLE, field regs/seen mask 0, FIFO empty, out_valid=0, out_tuple=0,
//   hdr_cnt=0, drop_cnt=0, overflow=0, hReady=1.
//  FSM IDLE: soh -> COLLECT. Field strobes are ignored unless soh is set the same cycle.
//   soh&eoh together form a one-word header that completes that cycle.
//  FSM COLLECT: field strobe -> capture into its register and set its seen bit.
//   eoh -> evaluate, then go to IDLE.
//   soh -> abort the current header (drop_cnt+1), restart collection with this word.
//  Errors: more than one field strobe in a cycle, or a field seen twice, sets err.
//   STRICT=1: err, or any of the 4 seen bits clear at eoh, drops the header (drop_cnt+1).
//   STRICT=0: multi-strobe still drops; duplicates take the last value; missing fields are 0.
//  Commit: push at the eoh edge. On an empty FIFO, out_valid rises the next cycle (latency 1).
//  Full at eoh with no same-cycle pop: tuple lost, overflow=1 for 1 cycle, drop_cnt+1.
//   A pop in the same cycle frees a slot and the push succeeds.
//  hReady = !full, registered from the FIFO count. Upstream holds soh while hReady=0.
//  Pop when out_valid&&out_ready; the next head is visible the following cycle.
//   out_tuple holds steady while out_valid&&!out_ready.
//  Counters saturate at 2^CNT_W-1 and never wrap; hdr_cnt+1 and drop_cnt+1 may occur together.
//  Async reset mid-header discards the partial header and all FIFO contents with no count.
// STRUCTURE
//  Package hdr_pkg: TUPLE_W=104, field offset/width localparams (SA_LSB=72, DA_LSB=40,
//   SP_LSB=24, DP_LSB=8, PROT_LSB=0), FSM state encodings (IDLE, COLLECT).
//  Sub-module hdr_tuple_fifo #(W,DEPTH): synchronous FWFT FIFO exposing full, empty and count.
//  The top level holds the FSM, field registers, seen/err flags and counters.
// TESTING
//  1 Words sa=0x0A000001, da=0x0A000002, sp_dp=0x00500050, prot=0x06, soh on sa, eoh on prot
//    -> out_tuple=0x0A000001_0A000002_0050_0050_06 one cycle after eoh; hdr_cnt=1.
//  2 STRICT=1, header without prot -> no push, drop_cnt=1.
//    STRICT=0, same stimulus -> tuple pushed with prot=0x00.
//  3 out_ready=0, push DEPTH headers -> hReady=0. Force a 5th eoh -> overflow pulse, drop_cnt=1.
//    Repeat with out_ready=1 on that cycle -> push accepted, no overflow.
//  4 soh mid-header, then a complete header -> drop_cnt=1, only the second tuple emitted.
//  5 Two field strobes in one cycle -> header dropped in both modes.
//    Preload hdr_cnt near all-ones -> holds at 0x3FF, no wrap.
//  6 Assert rst_n low with 2 tuples queued and a header half-collected
//    -> out_valid=0 and counters 0 immediately; the next full header is emitted normally.

Source files
------------

// File: rtl/hdr_pkg.sv
// Shared constants, state encoding and tuple packing for the header tuple collector.
package hdr_pkg;

    localparam int TUPLE_W  = 104;
    localparam int ADDR_W   = 32;
    localparam int PORT_W   = 16;
    localparam int PROT_W   = 8;
    localparam int SA_LSB   = 72;
    localparam int DA_LSB   = 40;
    localparam int SP_LSB   = 24;
    localparam int DP_LSB   = 8;
    localparam int PROT_LSB = 0;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    function automatic logic [TUPLE_W-1:0] pack_tuple(
        input logic [ADDR_W-1:0] sa_v,
        input logic [ADDR_W-1:0] da_v,
        input logic [PORT_W-1:0] sp_v,
        input logic [PORT_W-1:0] dp_v,
        input logic [PROT_W-1:0] prot_v
    );
        logic [TUPLE_W-1:0] t;
        t = '0;
        t[SA_LSB   +: ADDR_W] = sa_v;
        t[DA_LSB   +: ADDR_W] = da_v;
        t[SP_LSB   +: PORT_W] = sp_v;
        t[DP_LSB   +: PORT_W] = dp_v;
        t[PROT_LSB +: PROT_W] = prot_v;
        return t;
    endfunction

endpackage

// File: rtl/hdr_tuple_fifo.sv
// First-word fall-through tuple FIFO; a push into a full FIFO succeeds only with a same-cycle pop.
module hdr_tuple_fifo #(
    parameter int W     = 104,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    // Gate the head so an empty FIFO presents zeros rather than stale storage.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/header_tuple_collector.sv
// Collects {sa,da,sp,dp,prot} from the preprocessing word stream, validates it and queues
// finished tuples for the rule stage.
//   state   | meaning
//   IDLE    | between headers; only a word with soh is looked at
//   COLLECT | header open; strobes captured until eoh (or aborted by a new soh)
module header_tuple_collector
    import hdr_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int STRICT = 1,
    parameter int CNT_W  = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        data,
    input  logic               sa,
    input  logic               da,
    input  logic               sp_dp,
    input  logic               prot,
    input  logic               soh,
    input  logic               eoh,
    output logic               hReady,
    output logic [TUPLE_W-1:0] out_tuple,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   hdr_cnt,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic               overflow
);

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   sa_q, da_q, sa_n, da_n;
    logic [PORT_W-1:0]   sp_q, dp_q, sp_n, dp_n;
    logic [PROT_W-1:0]   prot_q, prot_n;
    logic [3:0]          seen_q, seen_n, seen_base, strobes;
    logic                dup_q, dup_n, multi_q, multi_n;
    logic                active, abort, done, good, commit, lost, pop;
    logic                full, empty;
    logic [$clog2(DEPTH):0] count;
    logic [1:0]          drop_inc;
    logic [CNT_W:0]      hdr_sum, drop_sum;

    assign strobes   = {sa, da, sp_dp, prot};
    assign active    = soh || (state == COLLECT);
    assign abort     = soh && (state == COLLECT);
    assign seen_base = soh ? 4'b0000 : seen_q;

    // A soh word starts from cleared fields, so anything never strobed reads back as zero.
    always_comb begin
        sa_n    = soh ? '0 : sa_q;
        da_n    = soh ? '0 : da_q;
        sp_n    = soh ? '0 : sp_q;
        dp_n    = soh ? '0 : dp_q;
        prot_n  = soh ? '0 : prot_q;
        if (sa)    sa_n   = data;
        if (da)    da_n   = data;
        if (sp_dp) begin
            sp_n = data[31:16];
            dp_n = data[15:0];
        end
        if (prot)  prot_n = data[7:0];
        seen_n  = seen_base | strobes;
        dup_n   = (soh ? 1'b0 : dup_q) | (|(seen_base & strobes));
        multi_n = (soh ? 1'b0 : multi_q) | ((strobes & (strobes - 4'd1)) != 4'd0);
    end

    always_comb begin
        done     = active && eoh;
        good     = !multi_n && ((STRICT == 0) || (!dup_n && (seen_n == 4'hF)));
        commit   = done && good;
        pop      = out_valid && out_ready;
        lost     = commit && full && !pop;
        drop_inc = {1'b0, abort} + {1'b0, done && !good} + {1'b0, lost};
        state_nx = (active && !eoh) ? COLLECT : IDLE;
    end

    assign hdr_sum  = {1'b0, hdr_cnt}  + {{CNT_W{1'b0}}, commit && !lost};
    assign drop_sum = {1'b0, drop_cnt} + {{(CNT_W-1){1'b0}}, drop_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sa_q     <= '0;
            da_q     <= '0;
            sp_q     <= '0;
            dp_q     <= '0;
            prot_q   <= '0;
            seen_q   <= '0;
            dup_q    <= 1'b0;
            multi_q  <= 1'b0;
            hdr_cnt  <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            overflow <= lost;
            if (active) begin
                sa_q    <= sa_n;
                da_q    <= da_n;
                sp_q    <= sp_n;
                dp_q    <= dp_n;
                prot_q  <= prot_n;
                seen_q  <= seen_n;
                dup_q   <= dup_n;
                multi_q <= multi_n;
            end
            // Carry out of the top bit means the count would pass all-ones: hold there.
            hdr_cnt  <= hdr_sum[CNT_W]  ? '1 : hdr_sum[CNT_W-1:0];
            drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end

    hdr_tuple_fifo #(
        .W     (TUPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (commit),
        .push_data (pack_tuple(sa_n, da_n, sp_n, dp_n, prot_n)),
        .pop       (pop),
        .pop_data  (out_tuple),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign out_valid = !empty;
    assign hReady    = (count != ($clog2(DEPTH) + 1)'(DEPTH));

endmodule

// File: tb/tb_header_tuple_collector.sv
// Drives a strict and a lenient collector from one word stream and checks both against a
// header-level model every cycle, plus hand-computed expectations.
module tb_header_tuple_collector;

    localparam int DEPTH = 4;
    localparam int CNT_W = 10;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data;
    logic        sa, da, sp_dp, prot, soh, eoh, out_ready;

    logic         hready [2];
    logic [103:0] tuple  [2];
    logic         valid  [2];
    logic [CNT_W-1:0] hcnt [2];
    logic [CNT_W-1:0] dcnt [2];
    logic         ovf    [2];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    header_tuple_collector #(.DEPTH(DEPTH), .STRICT(1), .CNT_W(CNT_W)) dut_strict (
        .clk(clk), .rst_n(rst_n), .data(data), .sa(sa), .da(da), .sp_dp(sp_dp), .prot(prot),
        .soh(soh), .eoh(eoh), .hReady(hready[0]), .out_tuple(tuple[0]), .out_valid(valid[0]),
        .out_ready(out_ready), .hdr_cnt(hcnt[0]), .drop_cnt(dcnt[0]), .overflow(ovf[0]));

    header_tuple_collector #(.DEPTH(DEPTH), .STRICT(0), .CNT_W(CNT_W)) dut_lenient (
        .clk(clk), .rst_n(rst_n), .data(data), .sa(sa), .da(da), .sp_dp(sp_dp), .prot(prot),
        .soh(soh), .eoh(eoh), .hReady(hready[1]), .out_tuple(tuple[1]), .out_valid(valid[1]),
        .out_ready(out_ready), .hdr_cnt(hcnt[1]), .drop_cnt(dcnt[1]), .overflow(ovf[1]));

    task automatic chk(input string name, input logic [103:0] act, input logic [103:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Header-level model: per-field strobe counts decide the verdict; queues hold tuples.
    bit           in_hdr;
    logic [31:0]  m_sa, m_da;
    logic [15:0]  m_sp, m_dp;
    logic [7:0]   m_pr;
    int           fcnt [4];
    bit           m_multi;
    logic [103:0] mq0 [$];
    logic [103:0] mq1 [$];
    int           mh [2];
    int           md [2];
    bit           movf [2];

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_hdr = 0; m_multi = 0;
            m_sa = 0; m_da = 0; m_sp = 0; m_dp = 0; m_pr = 0;
            for (int i = 0; i < 4; i++) fcnt[i] = 0;
            mq0.delete(); mq1.delete();
            for (int m = 0; m < 2; m++) begin mh[m] = 0; md[m] = 0; movf[m] = 0; end
        end else begin
            bit abort_h, done_h, good_h, lost_h;
            int nq;
            logic [103:0] t;
            abort_h = in_hdr && soh;
            done_h = 0;
            if (soh) begin
                in_hdr = 1; m_multi = 0;
                m_sa = 0; m_da = 0; m_sp = 0; m_dp = 0; m_pr = 0;
                for (int i = 0; i < 4; i++) fcnt[i] = 0;
            end
            if (in_hdr) begin
                if (int'(sa) + int'(da) + int'(sp_dp) + int'(prot) > 1) m_multi = 1;
                if (sa)    begin fcnt[0]++; m_sa = data; end
                if (da)    begin fcnt[1]++; m_da = data; end
                if (sp_dp) begin fcnt[2]++; m_sp = data[31:16]; m_dp = data[15:0]; end
                if (prot)  begin fcnt[3]++; m_pr = data[7:0]; end
                if (eoh) begin done_h = 1; in_hdr = 0; end
            end
            t = {m_sa, m_da, m_sp, m_dp, m_pr};
            for (int m = 0; m < 2; m++) begin
                if (m == 0) good_h = !m_multi && fcnt[0] == 1 && fcnt[1] == 1 && fcnt[2] == 1 && fcnt[3] == 1;
                else        good_h = !m_multi;
                if (m == 0 && mq0.size() > 0 && out_ready) void'(mq0.pop_front());
                if (m == 1 && mq1.size() > 0 && out_ready) void'(mq1.pop_front());
                nq = (m == 0) ? mq0.size() : mq1.size();
                lost_h = 0;
                if (done_h && good_h) begin
                    if (nq < DEPTH) begin
                        if (m == 0) mq0.push_back(t); else mq1.push_back(t);
                    end else lost_h = 1;
                end
                movf[m] = lost_h;
                mh[m] = sat(mh[m] + int'(done_h && good_h && !lost_h));
                md[m] = sat(md[m] + int'(abort_h) + int'(done_h && !good_h) + int'(lost_h));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int m = 0; m < 2; m++) begin
                int n;
                n = (m == 0) ? mq0.size() : mq1.size();
                chk($sformatf("out_valid[%0d]", m), 104'(valid[m]), 104'(n > 0));
                if (n > 0)
                    chk($sformatf("out_tuple[%0d]", m), tuple[m], (m == 0) ? mq0[0] : mq1[0]);
                chk($sformatf("hReady[%0d]", m), 104'(hready[m]), 104'(n < DEPTH));
                chk($sformatf("hdr_cnt[%0d]", m), 104'(hcnt[m]), 104'(mh[m]));
                chk($sformatf("drop_cnt[%0d]", m), 104'(dcnt[m]), 104'(md[m]));
                chk($sformatf("overflow[%0d]", m), 104'(ovf[m]), 104'(movf[m]));
            end
        end
    end

    // f = {sa, da, sp_dp, prot, soh, eoh}
    task automatic drive(input logic [31:0] d, input logic [5:0] f);
        data = d;
        {sa, da, sp_dp, prot, soh, eoh} = f;
        @(posedge clk);
        #2;
        {sa, da, sp_dp, prot, soh, eoh} = 6'b0;
        data = '0;
    endtask

    task automatic hdr_head(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        drive(a, 6'b1000_10);
        drive(b, 6'b0100_00);
        drive(c, 6'b0010_00);
    endtask

    task automatic hdr4(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [7:0] p);
        hdr_head(a, b, c);
        drive({24'h0, p}, 6'b0001_01);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (DEPTH + 1) @(posedge clk);
        #2;
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        data = '0;
        {sa, da, sp_dp, prot, soh, eoh} = 6'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("rst out_valid", 104'(valid[m]), 104'(0));
            chk("rst out_tuple", tuple[m], 104'(0));
            chk("rst hReady", 104'(hready[m]), 104'(1));
            chk("rst hdr_cnt", 104'(hcnt[m]), 104'(0));
            chk("rst drop_cnt", 104'(dcnt[m]), 104'(0));
            chk("rst overflow", 104'(ovf[m]), 104'(0));
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Stray strobe in IDLE is ignored, then a full header.
        drive(32'hDEADBEEF, 6'b1000_00);
        hdr4(32'h0A000001, 32'h0A000002, 32'h00500050, 8'h06);
        for (int m = 0; m < 2; m++) begin
            chk("t1 out_valid", 104'(valid[m]), 104'(1));
            chk("t1 out_tuple", tuple[m], 104'h0A000001_0A000002_0050_0050_06);
            chk("t1 hdr_cnt", 104'(hcnt[m]), 104'(1));
        end
        drain();

        // Missing prot.
        hdr_head(32'hC0A80001, 32'hC0A80002, 32'h1F900035);
        eoh = 1'b1; drive(32'hC0A80002, 6'b0000_01);
        chk("t2 strict drop_cnt", 104'(dcnt[0]), 104'(1));
        chk("t2 strict out_valid", 104'(valid[0]), 104'(0));
        chk("t2 lenient out_tuple", tuple[1], 104'hC0A80001_C0A80002_1F90_0035_00);
        drain();

        // Fill the FIFO, overflow once, then a full-cycle push rescued by a pop.
        for (int i = 0; i < DEPTH; i++)
            hdr4(32'h01000000 + i, 32'h02000000 + i, 32'h00010002 + i, 8'h11);
        chk("t3 hReady strict", 104'(hready[0]), 104'(0));
        chk("t3 hReady lenient", 104'(hready[1]), 104'(0));
        hdr4(32'h05050505, 32'h06060606, 32'h07070707, 8'h08);
        chk("t3 overflow strict", 104'(ovf[0]), 104'(1));
        chk("t3 overflow lenient", 104'(ovf[1]), 104'(1));
        chk("t3 drop strict", 104'(dcnt[0]), 104'(2));
        chk("t3 drop lenient", 104'(dcnt[1]), 104'(1));
        hdr_head(32'h09090909, 32'h0A0A0A0A, 32'h0B0B0B0B);
        out_ready = 1'b1;
        drive(32'h0000000C, 6'b0001_01);
        out_ready = 1'b0;
        chk("t3 no overflow", 104'(ovf[0]), 104'(0));
        chk("t3 hdr strict", 104'(hcnt[0]), 104'(6));
        chk("t3 hdr lenient", 104'(hcnt[1]), 104'(7));
        drain();

        // soh mid-header aborts the first.
        drive(32'hAAAA0001, 6'b1000_10);
        drive(32'hAAAA0002, 6'b0100_00);
        hdr4(32'hBBBB0001, 32'hBBBB0002, 32'h12345678, 8'h11);
        chk("t4 drop strict", 104'(dcnt[0]), 104'(3));
        chk("t4 drop lenient", 104'(dcnt[1]), 104'(2));
        chk("t4 tuple", tuple[0], 104'hBBBB0001_BBBB0002_1234_5678_11);
        drain();

        // Two strobes in one cycle, then drive counters into saturation.
        drive(32'h11111111, 6'b1100_11);
        chk("t5 multi drop strict", 104'(dcnt[0]), 104'(4));
        chk("t5 multi drop lenient", 104'(dcnt[1]), 104'(3));
        out_ready = 1'b1;
        for (int i = 0; i < 1030; i++) drive(32'h20000000 + i, 6'b1000_11);
        chk("t5 hdr sat lenient", 104'(hcnt[1]), 104'h3FF);
        chk("t5 drop sat strict", 104'(dcnt[0]), 104'h3FF);
        out_ready = 1'b0;
        drain();

        // Reset with tuples queued and a header half-collected.
        hdr4(32'h30000001, 32'h30000002, 32'h00030004, 8'h05);
        hdr4(32'h40000001, 32'h40000002, 32'h00040005, 8'h06);
        drive(32'h50000001, 6'b1000_10);
        drive(32'h50000002, 6'b0100_00);
        #1;
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("t6 out_valid", 104'(valid[m]), 104'(0));
            chk("t6 hdr_cnt", 104'(hcnt[m]), 104'(0));
            chk("t6 drop_cnt", 104'(dcnt[m]), 104'(0));
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        hdr4(32'h0A000001, 32'h0A000002, 32'h00500050, 8'h06);
        for (int m = 0; m < 2; m++) begin
            chk("t6 post tuple", tuple[m], 104'h0A000001_0A000002_0050_0050_06);
            chk("t6 post hdr_cnt", 104'(hcnt[m]), 104'(1));
        end
        drain();
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
